// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// State encoding and BCD digit limits.
package bcd_countdown_timer_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

endpackage

// File: rtl/bcd_countdown_timer_tick_gen.sv
// Prescaler for the BCD countdown timer.
// Raises tick on the last cycle of each TICK_DIV-cycle period.
module tick_gen
  import bcd_countdown_timer_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(TICK_DIV - 1));
  assign tick = enable && wrap;

  // Period counter; holds its value while disabled so a
  // resumed run finishes the partial period.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Four-digit BCD countdown timer with load/start/pause strobes.
// Optional warn output when COUNTDOWN_WARN_EN is defined.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] bcd,
`ifdef COUNTDOWN_WARN_EN
  output logic        warn,
`endif
  output logic        running,
  output logic        expired,
  output logic        done
);

  state_t      st, st_nx;
  logic [15:0] bcd_nx;
  logic [15:0] bcd_dec;
  logic [15:0] bcd_clamp;
  logic        exp_nx;
  logic        tick;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .enable  (st == RUN),
    .clear   (load),
    .tick    (tick)
  );

  // Ripple-borrow BCD decrement: a 0 digit wraps to 9
  // and borrows from the next digit up.
  always_comb begin
    logic brw;
    bcd_dec = bcd;
    brw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (brw) begin
        if (bcd[i*BCD_W +: BCD_W] == '0) begin
          bcd_dec[i*BCD_W +: BCD_W] = BCD_MAX;
        end else begin
          bcd_dec[i*BCD_W +: BCD_W] =
            bcd[i*BCD_W +: BCD_W] - BCD_W'(1);
          brw = 1'b0;
        end
      end
    end
  end

  // Saturate non-decimal load digits to 9.
  always_comb begin
    bcd_clamp = load_val;
    for (int i = 0; i < 4; i++) begin
      if (load_val[i*BCD_W +: BCD_W] > BCD_MAX) begin
        bcd_clamp[i*BCD_W +: BCD_W] = BCD_MAX;
      end
    end
  end

  // Next state: load dominates, then tick, pause, start.
  always_comb begin
    st_nx  = st;
    bcd_nx = bcd;
    exp_nx = 1'b0;
    if (load) begin
      st_nx  = IDLE;
      bcd_nx = bcd_clamp;
    end else begin
      if (tick) begin
        bcd_nx = bcd_dec;
        if (bcd_dec == '0) begin
          st_nx  = EXPIRED;
          exp_nx = 1'b1;
        end
      end
      if (st_nx == RUN && pause) begin
        st_nx = PAUSE;
      end else if ((st == IDLE || st == PAUSE)
                   && start && bcd != '0) begin
        st_nx = RUN;
      end
    end
  end

  // State, count and registered status outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      st      <= IDLE;
      bcd     <= '0;
      expired <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      st      <= st_nx;
      bcd     <= bcd_nx;
      expired <= exp_nx;
      running <= (st_nx == RUN);
      done    <= (st_nx == EXPIRED);
    end
  end

`ifdef COUNTDOWN_WARN_EN
  // Low-count warning while the count is live.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      warn <= 1'b0;
    end else begin
      warn <= (st_nx == RUN || st_nx == PAUSE)
              && bcd_nx <= 16'h0009;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer (TICK_DIV=4).
// Reference model works on decimal integers.
module tb_bcd_countdown_timer;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] bcd;
  logic        running, expired, done;
`ifdef COUNTDOWN_WARN_EN
  logic        warn;
`endif

  bcd_countdown_timer #(.TICK_DIV(TD)) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .load    (load),
    .load_val(load_val),
    .start   (start),
    .pause   (pause),
    .bcd     (bcd),
`ifdef COUNTDOWN_WARN_EN
    .warn    (warn),
`endif
    .running (running),
    .expired (expired),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] b;
    logic        r, e, d, w;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_pop = 0;

  // Model: 0 idle, 1 run, 2 paused, 3 expired
  int m_st = 0;
  int m_val = 0;
  int m_ph = 0;

  task automatic chk(string nm, logic [15:0] act,
                     logic [15:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic int clampdec(logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) begin
      int d;
      d = int'((v >> (4 * i)) & 16'hF);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(int x);
    return {4'(x / 1000 % 10), 4'(x / 100 % 10),
            4'(x / 10 % 10), 4'(x % 10)};
  endfunction

  task automatic model_step(logic ld, logic [15:0] lv,
                            logic s, logic p);
    exp_t e;
    logic tk;
    e.e = 1'b0;
    if (ld) begin
      m_val = clampdec(lv);
      m_st = 0;
      m_ph = 0;
    end else begin
      tk = (m_st == 1 && m_ph == TD - 1);
      if (m_st == 1) m_ph = (m_ph + 1) % TD;
      if (tk) begin
        m_val = m_val - 1;
        if (m_val == 0) begin
          m_st = 3;
          e.e = 1'b1;
        end
      end
      if (m_st == 1 && p) m_st = 2;
      else if ((m_st == 0 || m_st == 2) && s
               && m_val != 0) m_st = 1;
    end
    e.b = to_bcd(m_val);
    e.r = (m_st == 1);
    e.d = (m_st == 3);
    e.w = (m_st == 1 || m_st == 2) && m_val <= 9;
    q.push_back(e);
    n_push++;
  endtask

  task automatic cyc(logic ld, logic [15:0] lv,
                     logic s, logic p);
    @(negedge clk);
    load = ld;
    load_val = lv;
    start = s;
    pause = p;
    model_step(ld, lv, s, p);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, 0);
  endtask

  task automatic pchk(string nm, logic [15:0] b,
                      logic r, logic e, logic d);
    @(posedge clk);
    #2;
    chk({nm, ".bcd"}, bcd, b);
    chk({nm, ".run"}, 16'(running), 16'(r));
    chk({nm, ".exp"}, 16'(expired), 16'(e));
    chk({nm, ".done"}, 16'(done), 16'(d));
  endtask

  task automatic do_reset(string nm);
    exp_t e;
    @(negedge clk);
    load = 0;
    start = 0;
    pause = 0;
    m_st = 0;
    m_val = 0;
    m_ph = 0;
    e = '{b: 16'h0, r: 0, e: 0, d: 0, w: 0};
    q.push_back(e);
    n_push++;
    #2 resetn = 1'b0;
    #1;
    chk({nm, ".bcd"}, bcd, 16'h0);
    chk({nm, ".flags"},
        16'({running, expired, done}), 16'h0);
    @(posedge clk);
    #3 resetn = 1'b1;
  endtask

  // Monitor: one expectation per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_pop++;
        chk("sb.bcd", bcd, e.b);
        chk("sb.run", 16'(running), 16'(e.r));
        chk("sb.exp", 16'(expired), 16'(e.e));
        chk("sb.done", 16'(done), 16'(e.d));
`ifdef COUNTDOWN_WARN_EN
        chk("sb.warn", 16'(warn), 16'(e.w));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic ld, s, p;
    logic [15:0] lv;
    #3;
    chk("rst.bcd", bcd, 16'h0);
    chk("rst.flags",
        16'({running, expired, done}), 16'h0);
    #20 resetn = 1'b1;

    // basic
    cyc(1, 16'h0003, 0, 0);
    cyc(0, '0, 1, 0);
    idle(3);
    cyc(0, '0, 0, 0);
    pchk("basic4", 16'h0002, 1, 0, 0);
    idle(4);
    pchk("basic8", 16'h0001, 1, 0, 0);
    idle(4);
    pchk("basic12", 16'h0000, 0, 1, 1);
    idle(1);
    pchk("basic13", 16'h0000, 0, 0, 1);
    idle(3);

    // borrow and clamp
    cyc(1, 16'h1000, 0, 0);
    cyc(0, '0, 1, 0);
    idle(4);
    pchk("borrow", 16'h0999, 1, 0, 0);
    cyc(1, 16'h00A5, 0, 0);
    pchk("clamp", 16'h0095, 0, 0, 0);

    // pause / resume
    cyc(1, 16'h0005, 0, 0);
    cyc(0, '0, 1, 0);
    idle(5);
    cyc(0, '0, 0, 1);
    pchk("pause", 16'h0004, 0, 0, 0);
    idle(20);
    pchk("hold", 16'h0004, 0, 0, 0);
    cyc(0, '0, 1, 0);
    pchk("resume0", 16'h0004, 1, 0, 0);
    idle(1);
    pchk("resume1", 16'h0004, 1, 0, 0);
    idle(1);
    pchk("resume2", 16'h0003, 1, 0, 0);

    // priority
    cyc(1, 16'h0007, 1, 0);
    pchk("ld_start", 16'h0007, 0, 0, 0);
    cyc(1, 16'h0001, 0, 0);
    cyc(0, '0, 1, 0);
    idle(3);
    cyc(1, 16'h0042, 0, 0);
    pchk("ld_tick", 16'h0042, 0, 0, 0);
    idle(6);

    // zero start, reset mid-run
    cyc(1, 16'h0000, 0, 0);
    cyc(0, '0, 1, 0);
    pchk("zero", 16'h0000, 0, 0, 0);
    cyc(1, 16'h0003, 0, 0);
    cyc(0, '0, 1, 0);
    idle(5);
    pchk("pre_rst", 16'h0002, 1, 0, 0);
    do_reset("rst_run");
    idle(12);
    pchk("post_rst", 16'h0000, 0, 0, 0);

`ifdef COUNTDOWN_WARN_EN
    cyc(1, 16'h0011, 0, 0);
    cyc(0, '0, 1, 0);
    idle(7);
    #6 chk("warn7", 16'(warn), 16'h0);
    idle(1);
    #6 chk("warn8", 16'(warn), 16'h1);
    idle(36);
    #6 chk("warn44", 16'({warn, done}), 16'h1);
`endif

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      ld = (r < 3);
      if ($urandom_range(0, 3) == 0) lv = 16'($urandom);
      else lv = 16'($urandom_range(0, 255));
      s = ($urandom_range(0, 99) < 12);
      p = !s && ($urandom_range(0, 99) < 5);
      cyc(ld, lv, s, p);
    end
    idle(2);

    for (int k = 0; k < 10 && q.size() != 0; k++)
      @(posedge clk);
    #3;
    chk("sb.drain", 16'(n_pop), 16'(n_push));

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
